// File: rtl/qupls_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : qupls_decode_stage
//  Purpose  : Multi-lane decode stage between fetch/align and rename. It
//             decodes each lane, squashes postfix and post-sync lanes, and
//             queues each group in a 2-entry skid buffer.
//  Revision : 1.0  initial release
// ============================================================================
module qupls_decode_stage #(
    parameter int LANES = 4,
    parameter int INS_W = 48,
    parameter int PC_W  = 32,
    parameter int DB_W  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*INS_W-1:0]  in_ins,
    input  logic [LANES*PC_W-1:0]   in_pc,
    input  logic [LANES-1:0]        in_lane_v,
    input  logic [LANES*4-1:0]      in_regx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_v,
    output logic [LANES*DB_W-1:0]   out_db,
    output logic [LANES*PC_W-1:0]   out_pc,
    output logic                    resteer_v,
    output logic [PC_W-1:0]         resteer_pc,
    input  logic                    sync_done
);

    localparam logic [6:0] c_OP_LOAD  = 7'h10;
    localparam logic [6:0] c_OP_STORE = 7'h11;
    localparam logic [6:0] c_OP_FENCE = 7'h12;
    localparam logic [6:0] c_OP_PFX   = 7'h13;

    // Decode bus record: [0] pfx, [1] fence, [2] load, [3] store, [4] mem,
    // [11:5] opcode, [15:12] regx, [16 +: INS_W] raw instruction, rest zero.
    function automatic logic [DB_W-1:0] decode_core(input logic [INS_W-1:0] ins,
                                                    input logic [3:0]       regx);
        logic [DB_W-1:0] db;
        logic [6:0]      op;
        db        = '0;
        op        = ins[6:0];
        db[0]     = (op == c_OP_PFX);
        db[1]     = (op == c_OP_FENCE);
        db[2]     = (op == c_OP_LOAD);
        db[3]     = (op == c_OP_STORE);
        db[4]     = (op == c_OP_LOAD) | (op == c_OP_STORE);
        db[11:5]  = op;
        db[15:12] = regx;
        db[16 +: INS_W] = ins;
        return db;
    endfunction

    typedef enum logic [0:0] {
        S_RUN       = 1'b0,
        S_SYNC_WAIT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0]              r_count;
    logic [LANES-1:0]        r_lv0, r_lv1;
    logic [LANES*DB_W-1:0]   r_db0, r_db1;
    logic [LANES*PC_W-1:0]   r_pc0, r_pc1;
    logic                    r_resteer_v;
    logic [PC_W-1:0]         r_resteer_pc;

    logic [LANES*DB_W-1:0]   w_db;
    logic [LANES-1:0]        w_sync;
    logic [LANES-1:0]        w_after;
    logic [LANES-1:0]        w_lane_v;
    logic                    w_has_sync;
    logic                    w_resteer;
    logic [PC_W-1:0]         w_rpc;
    logic                    w_push;
    logic                    w_pop;

    always_comb begin
        logic seen;
        w_db     = '0;
        w_sync   = '0;
        w_after  = '0;
        w_lane_v = '0;
        seen     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_db[i*DB_W +: DB_W] = decode_core(in_ins[i*INS_W +: INS_W], in_regx[i*4 +: 4]);
            w_sync[i]  = w_db[i*DB_W + 1] & (in_ins[i*INS_W + 8 +: 8] == 8'hFF);
            w_after[i] = seen;
            w_lane_v[i] = in_lane_v[i] & ~w_db[i*DB_W] & ~seen;
            if (in_lane_v[i] & w_sync[i])
                seen = 1'b1;
        end
        w_has_sync = seen;
        w_resteer  = |(in_lane_v & w_after);
    end

    // Descending scan so the lowest lane behind the fence (lane s+1) wins.
    always_comb begin
        w_rpc = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_after[i])
                w_rpc = in_pc[i*PC_W +: PC_W];
        end
    end

    assign in_ready   = (r_state == S_RUN) && (r_count != 2'd2);
    assign out_valid  = (r_count != 2'd0);
    assign out_lane_v = r_lv0;
    assign out_db     = r_db0;
    assign out_pc     = r_pc0;
    assign resteer_v  = r_resteer_v;
    assign resteer_pc = r_resteer_pc;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:       if (w_push && w_has_sync) w_state_next = S_SYNC_WAIT;
            S_SYNC_WAIT: if (sync_done)            w_state_next = S_RUN;
            default:     w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            r_state <= S_RUN;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= 2'd0;
            r_lv0        <= '0;
            r_lv1        <= '0;
            r_db0        <= '0;
            r_db1        <= '0;
            r_pc0        <= '0;
            r_pc1        <= '0;
            r_resteer_v  <= 1'b0;
            r_resteer_pc <= '0;
        end else if (flush) begin
            r_count     <= 2'd0;
            r_resteer_v <= 1'b0;
        end else begin
            r_resteer_v <= w_push & w_resteer;
            if (w_push && w_resteer)
                r_resteer_pc <= w_rpc;
            // Head is r_*0; a pop shifts entry 1 forward, a push fills the first free slot.
            if (w_push && (w_pop || r_count == 2'd0)) begin
                r_lv0 <= w_lane_v;
                r_db0 <= w_db;
                r_pc0 <= in_pc;
            end else if (w_push) begin
                r_lv1 <= w_lane_v;
                r_db1 <= w_db;
                r_pc1 <= in_pc;
            end else if (w_pop) begin
                r_lv0 <= r_lv1;
                r_db0 <= r_db1;
                r_pc0 <= r_pc1;
            end
            if (w_push && !w_pop)
                r_count <= r_count + 2'd1;
            else if (!w_push && w_pop)
                r_count <= r_count - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qupls_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qupls_decode_stage
//  Purpose  : Scoreboard bench for qupls_decode_stage with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qupls_decode_stage;

    localparam int LANES = 4;
    localparam int INS_W = 48;
    localparam int PC_W  = 32;
    localparam int DB_W  = 256;

    localparam int K_ALU   = 0;
    localparam int K_LD    = 1;
    localparam int K_ST    = 2;
    localparam int K_FENCE = 3;
    localparam int K_PFX   = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*INS_W-1:0] in_ins = '0;
    logic [LANES*PC_W-1:0]  in_pc = '0;
    logic [LANES-1:0]       in_lane_v = '0;
    logic [LANES*4-1:0]     in_regx = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [LANES-1:0]       out_lane_v;
    logic [LANES*DB_W-1:0]  out_db;
    logic [LANES*PC_W-1:0]  out_pc;
    logic                   resteer_v;
    logic [PC_W-1:0]        resteer_pc;
    logic                   sync_done = 1'b0;

    qupls_decode_stage #(.LANES(LANES), .INS_W(INS_W), .PC_W(PC_W), .DB_W(DB_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ins(in_ins), .in_pc(in_pc), .in_lane_v(in_lane_v), .in_regx(in_regx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_v(out_lane_v), .out_db(out_db), .out_pc(out_pc),
        .resteer_v(resteer_v), .resteer_pc(resteer_pc), .sync_done(sync_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES-1:0]      lv;
        logic [LANES*PC_W-1:0] pc;
        logic [LANES*DB_W-1:0] db;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [LANES*INS_W-1:0] g_ins;
    logic [LANES*PC_W-1:0]  g_pc;
    logic [LANES*4-1:0]     g_regx;
    logic [LANES*DB_W-1:0]  g_db;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected lane record built from the vector's own kind flags.
    task automatic set_lane(input int i, input int kind, input logic [7:0] hi,
                            input logic [PC_W-1:0] pc);
        logic [6:0]      op;
        logic [INS_W-1:0] ins;
        logic [3:0]      rx;
        logic [DB_W-1:0] db;
        case (kind)
            K_LD:    op = 7'h10;
            K_ST:    op = 7'h11;
            K_FENCE: op = 7'h12;
            K_PFX:   op = 7'h13;
            default: op = 7'h01;
        endcase
        ins = {16'h0, pc[15:0], hi, 1'b0, op};
        rx  = 4'(i * 3 + 1);
        db  = '0;
        db[0] = (kind == K_PFX);
        db[1] = (kind == K_FENCE);
        db[2] = (kind == K_LD);
        db[3] = (kind == K_ST);
        db[4] = (kind == K_LD) || (kind == K_ST);
        db[11:5] = op;
        db[15:12] = rx;
        db[16 +: INS_W] = ins;
        g_ins[i*INS_W +: INS_W] = ins;
        g_pc[i*PC_W +: PC_W]    = pc;
        g_regx[i*4 +: 4]        = rx;
        g_db[i*DB_W +: DB_W]    = db;
    endtask

    task automatic plain_group(input logic [PC_W-1:0] base);
        for (int i = 0; i < LANES; i++)
            set_lane(i, K_ALU, 8'h00, base + PC_W'(4 * i));
    endtask

    task automatic send(input logic [LANES-1:0] lv, input logic [LANES-1:0] exp_lv,
                        input bit expect_out);
        int   n;
        exp_t e;
        in_ins    = g_ins;
        in_pc     = g_pc;
        in_regx   = g_regx;
        in_lane_v = lv;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end else if (expect_out) begin
            e.lv = exp_lv; e.pc = g_pc; e.db = g_db;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every accepted output group is matched against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_group actual=lane_v %h pc %h required=none", out_lane_v, out_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_lane_v", 128'(out_lane_v), 128'(e.lv));
                chk("out_pc", 128'(out_pc), 128'(e.pc));
                total++;
                if (out_db !== e.db) begin
                    bad++;
                    for (int i = 0; i < LANES; i++) begin
                        if (out_db[i*DB_W +: DB_W] !== e.db[i*DB_W +: DB_W]) begin
                            $display("FAIL out_db lane%0d actual=%h required=%h", i,
                                     out_db[i*DB_W +: 64], e.db[i*DB_W +: 64]);
                            break;
                        end
                    end
                end
            end
        end
    end

    initial begin
        g_ins = '0; g_pc = '0; g_regx = '0; g_db = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_lane_v", 128'(out_lane_v), 128'd0);
        chk("rst_out_pc", 128'(out_pc), 128'd0);
        chk("rst_out_db_zero", 128'(|out_db), 128'd0);
        chk("rst_resteer", 128'({resteer_v, resteer_pc}), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);

        // Streaming at one group per cycle.
        plain_group(32'h0000_0100);
        send(4'hF, 4'hF, 1);
        chk("latency_valid", 128'(out_valid), 128'd1);
        plain_group(32'h0000_0200); send(4'hF, 4'hF, 1);
        plain_group(32'h0000_0300); send(4'h5, 4'h5, 1);
        chk("stream_in_ready", 128'(in_ready), 128'd1);
        repeat (2) @(posedge clk); #1;

        // Backpressure fills the skid buffer, then drains in order.
        out_ready = 1'b0;
        plain_group(32'h0000_A000); send(4'hF, 4'hF, 1);
        plain_group(32'h0000_B000); send(4'hF, 4'hF, 1);
        chk("full_in_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_b_head", 128'(out_pc[PC_W-1:0]), 128'h0000_B000);
        @(posedge clk); #1;
        chk("drain_empty", 128'(out_valid), 128'd0);
        chk("drain_in_ready", 128'(in_ready), 128'd1);

        // Postfix lane 2, load lane 1, non-sync fence lane 3.
        set_lane(0, K_ST,    8'h00, 32'h2000);
        set_lane(1, K_LD,    8'h00, 32'h2004);
        set_lane(2, K_PFX,   8'h00, 32'h2008);
        set_lane(3, K_FENCE, 8'h7F, 32'h200C);
        send(4'hF, 4'b1011, 1);
        chk("pfx_no_resteer", 128'(resteer_v), 128'd0);
        chk("pfx_in_ready", 128'(in_ready), 128'd1);

        // Sync fence in lane 1 squashes lanes 2,3 and resteers to lane 2.
        set_lane(0, K_ALU,   8'h00, 32'h1000);
        set_lane(1, K_FENCE, 8'hFF, 32'h1004);
        set_lane(2, K_ALU,   8'h00, 32'h1008);
        set_lane(3, K_ALU,   8'h00, 32'h100C);
        send(4'hF, 4'b0011, 1);
        chk("sync1_resteer_v", 128'(resteer_v), 128'd1);
        chk("sync1_resteer_pc", 128'(resteer_pc), 128'h1008);
        chk("sync1_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        chk("sync1_pulse_end", 128'(resteer_v), 128'd0);
        repeat (3) @(posedge clk); #1;
        chk("sync1_wait", 128'(in_ready), 128'd0);
        sync_done = 1'b1;
        @(posedge clk); #1;
        sync_done = 1'b0;
        chk("sync1_release", 128'(in_ready), 128'd1);

        // Sync fence in the last lane: nothing behind it, no resteer.
        plain_group(32'h3000);
        set_lane(3, K_FENCE, 8'hFF, 32'h300C);
        send(4'hF, 4'hF, 1);
        chk("sync3_no_resteer", 128'(resteer_v), 128'd0);
        chk("sync3_in_ready", 128'(in_ready), 128'd0);
        sync_done = 1'b1;
        @(posedge clk); #1;
        sync_done = 1'b0;
        chk("sync3_release", 128'(in_ready), 128'd1);

        // Full buffer in SYNC_WAIT, then flush with an incoming group.
        out_ready = 1'b0;
        plain_group(32'h4000); send(4'hF, 4'hF, 0);
        set_lane(3, K_FENCE, 8'hFF, 32'h400C);
        send(4'hF, 4'hF, 0);
        chk("syncfull_in_ready", 128'(in_ready), 128'd0);
        plain_group(32'h5000);
        in_ins = g_ins; in_pc = g_pc; in_regx = g_regx; in_lane_v = 4'hF;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        chk("flush_in_ready", 128'(in_ready), 128'd1);
        chk("flush_resteer", 128'(resteer_v), 128'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("flush_dropped", 128'(out_valid), 128'd0);

        // Reset in the middle of a full-buffer stall.
        out_ready = 1'b0;
        plain_group(32'h6000); send(4'hF, 4'hF, 0);
        plain_group(32'h7000); send(4'hF, 4'hF, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_out_valid", 128'(out_valid), 128'd0);
        chk("rst2_lane_v_pc", 128'({out_lane_v, out_pc}), 128'd0);
        chk("rst2_out_db_zero", 128'(|out_db), 128'd0);
        chk("rst2_in_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        plain_group(32'h8000);
        set_lane(2, K_ST, 8'h00, 32'h8008);
        send(4'hE, 4'hE, 1);

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("scoreboard_empty", 128'(q.size()), 128'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
